// File: rtl/data_sram_responder_pkg.sv
// data_sram_responder_pkg
// Shared definitions for the SRAM-like data interface responder:
//   - bus widths for address, data and byte strobes
//   - size encodings carried on data_sram_size (byte / half / word)
//   - a default response latency used by the simulation tops
//   - merge_lanes(): byte-lane merge of store data into an existing word
package data_sram_responder_pkg;

  localparam int ADDR_W          = 32;
  localparam int DATA_W          = 32;
  localparam int STRB_W          = DATA_W / 8;
  localparam int DEFAULT_LATENCY = 2;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } sram_size_e;

  // Replace every byte lane whose strobe bit is set with the matching lane of
  // new_word; lanes with a clear strobe keep the old contents.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_resp_delay_line.sv
// sram_resp_delay_line
// Fixed-depth shift pipeline carrying {valid, data} for in-order responses.
// An entry presented on in_valid appears on out_valid/out_data DEPTH edges
// later. The data field of an invalid stage is always zero, so out_data is
// zero whenever out_valid is low. Synchronous active-high reset empties it.
// Ports:
//   clk       clock
//   reset     synchronous active-high clear of all stages
//   in_valid  entry valid, captured at this edge
//   in_data   entry payload
//   out_valid last stage valid
//   out_data  last stage payload (zero when out_valid is low)
module sram_resp_delay_line
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_LATENCY,
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  // Next-state of the shift: stage 0 takes the new entry (payload forced to
  // zero when not valid), every later stage takes its predecessor.
  always_comb begin
    valid_d[0] = in_valid;
    data_d[0]  = in_valid ? in_data : '0;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  // Stage registers; reset drops every in-flight entry and zeroes payloads.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder
// Slave end of the SRAM-like data interface. Backs a word-addressed array,
// accepts one request per cycle and answers in order after LATENCY cycles.
// The memory stage cannot back-pressure data_ok, so the number of accepted
// but unanswered transfers is capped at MAX_OUTSTANDING. With STALL_EN set,
// addr_ok is additionally gated by bit 0 of a free-running 16-bit LFSR to
// exercise requester stall paths.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   data_sram_req          request valid
//   data_sram_wr           1 = store, 0 = load
//   data_sram_size         access size (informational; wstrb decides lanes)
//   data_sram_addr         byte address; [1:0] ignored, upper bits alias
//   data_sram_wstrb        byte write enables for stores
//   data_sram_wdata        lane-aligned store data
//   data_sram_addr_ok      request accepted this cycle (combinational)
//   data_sram_data_ok      one-cycle response pulse per transfer
//   data_sram_rdata        load word, zero for store responses and idle cycles
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          MEM_WORDS       = 4096,
  parameter int          LATENCY         = DEFAULT_LATENCY,
  parameter int          MAX_OUTSTANDING = 2,
  parameter bit          STALL_EN        = 1'b0,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [STRB_W-1:0] data_sram_wstrb,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [DATA_W-1:0] data_sram_rdata
);

  localparam int              IDX_W   = $clog2(MEM_WORDS);
  localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wword_d;
  logic [DATA_W-1:0] resp_data_d;
  logic              accept;
  logic              stall_ok;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [15:0]       lfsr_q;
  logic [15:0]       lfsr_d;
  logic              unused_bits;

  // Size is informational and the address bits outside the word index do
  // not take part in decoding.
  assign unused_bits = ^{data_sram_size, data_sram_addr[1:0],
                         data_sram_addr[ADDR_W-1:IDX_W+2]};

  // Handshake and array access. addr_ok looks only at the registered count:
  // a slot freed by this cycle's data_ok is not reusable until next cycle,
  // so a stream at MAX_OUTSTANDING = LATENCY settles at LATENCY accepts per
  // LATENCY+1 cycles. Loads read the array combinationally in the accept
  // cycle; a store and a load never share an edge, so no bypass is needed.
  always_comb begin
    mem_idx           = data_sram_addr[IDX_W+1:2];
    stall_ok          = !STALL_EN || lfsr_q[0];
    data_sram_addr_ok = data_sram_req && (cnt_q < CNT_MAX) && stall_ok && !reset;
    accept            = data_sram_req && data_sram_addr_ok;
    mem_wword_d       = merge_lanes(mem_q[mem_idx], data_sram_wdata, data_sram_wstrb);
    resp_data_d       = data_sram_wr ? '0 : mem_q[mem_idx];
  end

  // Backing array. Deliberately not cleared by reset so stores accepted
  // before a reset survive it; contents come from stores or a simulation
  // preload.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      mem_q[mem_idx] <= mem_wword_d;
    end
  end

  // Outstanding counter and stall LFSR next-state. The LFSR is a right-shift
  // Fibonacci register with taps 16,14,13,11, and holds its seed when stall
  // injection is disabled.
  always_comb begin
    cnt_d = cnt_q;
    case ({accept, data_sram_data_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (STALL_EN) begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // Counter and LFSR registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      lfsr_q <= LFSR_SEED;
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
    end
  end

  // Response pipeline: the transfer accepted at edge k leaves the last stage
  // in the cycle after edge k+LATENCY-1.
  sram_resp_delay_line #(
    .DEPTH (LATENCY),
    .WIDTH (DATA_W)
  ) u_delay_line (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept),
    .in_data   (resp_data_d),
    .out_valid (data_sram_data_ok),
    .out_data  (data_sram_rdata)
  );

endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder
// Four responder instances share clock and reset, each with its own bus:
//   0: LATENCY 2, MAX 2, 4096 words   (word/partial stores, aliasing)
//   1: LATENCY 3, MAX 2               (outstanding limit, mid-flight reset)
//   2: LATENCY 1, MAX 1               (accept and response in one cycle)
//   3: LATENCY 2, MAX 2, STALL_EN     (random traffic against a scoreboard)
module tb_data_sram_responder;
  import data_sram_responder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]       req, wr, addr_ok, data_ok;
  logic [3:0][1:0]  size;
  logic [3:0][31:0] addr, wdata, rdata;
  logic [3:0][3:0]  wstrb;

  int n_compared;
  int n_mismatched;

  logic [15:0] lfsr_model;
  logic [31:0] sb_mem [16];

  data_sram_responder #(.MEM_WORDS(4096), .LATENCY(2), .MAX_OUTSTANDING(2)) dut_a (
    .clk(clk), .reset(reset), .data_sram_req(req[0]), .data_sram_wr(wr[0]),
    .data_sram_size(size[0]), .data_sram_addr(addr[0]), .data_sram_wstrb(wstrb[0]),
    .data_sram_wdata(wdata[0]), .data_sram_addr_ok(addr_ok[0]),
    .data_sram_data_ok(data_ok[0]), .data_sram_rdata(rdata[0]));

  data_sram_responder #(.MEM_WORDS(256), .LATENCY(3), .MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .reset(reset), .data_sram_req(req[1]), .data_sram_wr(wr[1]),
    .data_sram_size(size[1]), .data_sram_addr(addr[1]), .data_sram_wstrb(wstrb[1]),
    .data_sram_wdata(wdata[1]), .data_sram_addr_ok(addr_ok[1]),
    .data_sram_data_ok(data_ok[1]), .data_sram_rdata(rdata[1]));

  data_sram_responder #(.MEM_WORDS(256), .LATENCY(1), .MAX_OUTSTANDING(1)) dut_c (
    .clk(clk), .reset(reset), .data_sram_req(req[2]), .data_sram_wr(wr[2]),
    .data_sram_size(size[2]), .data_sram_addr(addr[2]), .data_sram_wstrb(wstrb[2]),
    .data_sram_wdata(wdata[2]), .data_sram_addr_ok(addr_ok[2]),
    .data_sram_data_ok(data_ok[2]), .data_sram_rdata(rdata[2]));

  data_sram_responder #(.MEM_WORDS(256), .LATENCY(2), .MAX_OUTSTANDING(2),
                        .STALL_EN(1'b1), .LFSR_SEED(16'hACE1)) dut_s (
    .clk(clk), .reset(reset), .data_sram_req(req[3]), .data_sram_wr(wr[3]),
    .data_sram_size(size[3]), .data_sram_addr(addr[3]), .data_sram_wstrb(wstrb[3]),
    .data_sram_wdata(wdata[3]), .data_sram_addr_ok(addr_ok[3]),
    .data_sram_data_ok(data_ok[3]), .data_sram_rdata(rdata[3]));

  // Reference stall LFSR: right-shift Fibonacci, taps 16,14,13,11.
  always @(posedge clk) begin
    if (reset) lfsr_model <= 16'hACE1;
    else       lfsr_model <= {lfsr_model[0] ^ lfsr_model[2] ^ lfsr_model[3] ^ lfsr_model[5],
                              lfsr_model[15:1]};
  end

  function automatic int lat(input int sel);
    case (sel)
      1:       return 3;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int getCnt(input int sel);
    case (sel)
      0:       return int'(dut_a.cnt_q);
      1:       return int'(dut_b.cnt_q);
      2:       return int'(dut_c.cnt_q);
      default: return int'(dut_s.cnt_q);
    endcase
  endfunction

  function automatic logic [31:0] wordVal(input logic [31:0] a);
    return 32'h5EED_0000 + a;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic r, input logic w,
                               input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d);
    req[sel]   = r;
    wr[sel]    = w;
    size[sel]  = SIZE_WORD;
    addr[sel]  = a;
    wstrb[sel] = s;
    wdata[sel] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until the selected instance accepts it; returns just
  // after the accepting edge with req dropped.
  task automatic issueOp(input int sel, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
    bit acc;
    acc = 1'b0;
    applyStimulus(sel, 1'b1, w, a, s, d);
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk);
      if (sel == 3) checkOutput("stall_gate", addr_ok[3], lfsr_model[0]);
      acc = addr_ok[sel];
      tick();
    end
    req[sel] = 1'b0;
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Response must appear exactly in the cycle after edge k+LATENCY-1.
  task automatic awaitResp(input int sel, input string tag, input logic [31:0] exp);
    for (int i = 0; i < lat(sel) - 1; i++) begin
      @(negedge clk);
      checkOutput({tag, "_early"}, data_ok[sel], 32'd0);
      tick();
    end
    @(negedge clk);
    checkOutput({tag, "_dok"}, data_ok[sel], 32'd1);
    checkOutput({tag, "_rdata"}, rdata[sel], exp);
    tick();
  endtask

  task automatic preloadWord(input int sel, input logic [31:0] a, input logic [31:0] v);
    issueOp(sel, 1'b1, a, 4'hF, v);
    awaitResp(sel, "preload", 32'd0);
  endtask

  // Loads held continuously from address 0 upward; addr_ok, data_ok and cnt
  // follow hand-derived per-cycle tables, rdata follows an in-order queue.
  task automatic streamLoads(input int sel, input int ncyc, input string tag,
                             input bit [15:0] exp_ok, input bit [15:0] exp_dok,
                             input bit [31:0] exp_cnt);
    logic [31:0] pend[$];
    logic [31:0] next_addr;
    bit acc;
    next_addr = 32'd0;
    for (int c = 0; c < ncyc; c++) begin
      applyStimulus(sel, 1'b1, 1'b0, next_addr, 4'h0, 32'd0);
      @(negedge clk);
      checkOutput({tag, "_addr_ok"}, addr_ok[sel], exp_ok[c]);
      checkOutput({tag, "_data_ok"}, data_ok[sel], exp_dok[c]);
      checkOutput({tag, "_cnt"}, getCnt(sel), exp_cnt[2*c +: 2]);
      if (data_ok[sel]) begin
        if (pend.size() == 0) checkOutput({tag, "_extra"}, 32'd1, 32'd0);
        else checkOutput({tag, "_rdata"}, rdata[sel], pend.pop_front());
      end else begin
        checkOutput({tag, "_rdata_idle"}, rdata[sel], 32'd0);
      end
      acc = addr_ok[sel];
      if (acc) pend.push_back(wordVal(next_addr));
      tick();
      if (acc) next_addr = next_addr + 32'd4;
    end
    applyStimulus(sel, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (data_ok[sel]) begin
        if (pend.size() == 0) checkOutput({tag, "_extra"}, 32'd1, 32'd0);
        else checkOutput({tag, "_rdata"}, rdata[sel], pend.pop_front());
      end
      tick();
    end
    checkOutput({tag, "_left"}, pend.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] v, d, a;
    logic [3:0]  s;
    int          idx;
    n_compared   = 0;
    n_mismatched = 0;

    // Reset with requests pending: nothing may be accepted.
    reset = 1'b1;
    req   = '1;
    wr    = '0;
    size  = '0;
    addr  = '0;
    wstrb = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int sel = 0; sel < 4; sel++) checkOutput("rst_addr_ok", addr_ok[sel], 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
    for (int sel = 0; sel < 4; sel++) begin
      checkOutput("rst_data_ok", data_ok[sel], 32'd0);
      checkOutput("rst_rdata", rdata[sel], 32'd0);
      checkOutput("rst_cnt", getCnt(sel), 32'd0);
    end
    tick();

    // Word store then load, aliasing and ignored low address bits.
    issueOp(0, 1'b1, 32'h1C04, 4'hF, 32'hDEADBEEF);
    awaitResp(0, "word_st", 32'd0);
    issueOp(0, 1'b0, 32'h1C04, 4'h0, 32'd0);
    awaitResp(0, "word_ld", 32'hDEADBEEF);
    applyStimulus(0, 1'b0, 1'b1, 32'h1C04, 4'hF, 32'd0);
    @(negedge clk);
    checkOutput("noreq_addr_ok", addr_ok[0], 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("noreq_data_ok", data_ok[0], 32'd0);
      tick();
    end
    issueOp(0, 1'b0, 32'h5C04, 4'h0, 32'd0);
    awaitResp(0, "alias_ld", 32'hDEADBEEF);
    issueOp(0, 1'b0, 32'h1C07, 4'h0, 32'd0);
    awaitResp(0, "lowbits_ld", 32'hDEADBEEF);

    // Partial strobes and an all-zero strobe store.
    preloadWord(0, 32'h20, 32'h11223344);
    issueOp(0, 1'b1, 32'h20, 4'b0100, 32'h00AA0000);
    awaitResp(0, "part_st", 32'd0);
    issueOp(0, 1'b0, 32'h23, 4'h0, 32'd0);
    awaitResp(0, "part_ld", 32'h11AA3344);
    issueOp(0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF);
    awaitResp(0, "zstrb_st", 32'd0);
    issueOp(0, 1'b0, 32'h20, 4'h0, 32'd0);
    awaitResp(0, "zstrb_ld", 32'h11AA3344);

    // Outstanding limit, LATENCY 3 / MAX 2.
    for (int i = 0; i < 8; i++) preloadWord(1, 32'(4 * i), wordVal(32'(4 * i)));
    streamLoads(1, 9, "limit", 16'b1_0011_0011, 16'b1_1001_1000,
                32'b01_10_10_01_01_10_10_01_00);

    // Accept and response in the same cycle, LATENCY 1 / MAX 1.
    for (int i = 0; i < 8; i++) preloadWord(2, 32'(4 * i), wordVal(32'(4 * i)));
    streamLoads(2, 6, "simul", 16'b01_0101, 16'b10_1010, 32'b01_00_01_00_01_00);

    // Reset with a store and a load in flight: no responses, store kept.
    issueOp(1, 1'b1, 32'h44, 4'hF, 32'h5A5A1234);
    issueOp(1, 1'b0, 32'h0, 4'h0, 32'd0);
    reset = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, 32'h8, 4'h0, 32'd0);
    @(negedge clk);
    checkOutput("midrst_addr_ok", addr_ok[1], 32'd0);
    checkOutput("midrst_early", data_ok[1], 32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    req[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("midrst_data_ok", data_ok[1], 32'd0);
      checkOutput("midrst_cnt", getCnt(1), 32'd0);
      tick();
    end
    issueOp(1, 1'b0, 32'h44, 4'h0, 32'd0);
    awaitResp(1, "persist_ld", 32'h5A5A1234);

    // Stall mode: random traffic against a word-level scoreboard.
    for (int i = 0; i < 16; i++) begin
      v = 32'h3000_0000 + 32'(i) * 32'h0101_0101;
      preloadWord(3, 32'h300 + 32'(4 * i), v);
      sb_mem[i] = v;
    end
    for (int n = 0; n < 100; n++) begin
      idx = int'($urandom_range(15));
      a   = 32'h300 + 32'(4 * idx);
      if ($urandom_range(1) == 1) begin
        s = 4'($urandom_range(15));
        d = $urandom;
        issueOp(3, 1'b1, a, s, d);
        for (int l = 0; l < 4; l++) if (s[l]) sb_mem[idx][8*l +: 8] = d[8*l +: 8];
        awaitResp(3, "stall_st", 32'd0);
      end else begin
        issueOp(3, 1'b0, a + 32'($urandom_range(3)), 4'h0, 32'd0);
        awaitResp(3, "stall_ld", sb_mem[idx]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
